student_sample_ring: RTL and testbench

- Multi-channel circular sample history buffer for the FIR datapath, built on one inferred block RAM (read-first, single clock).
- Accepts one new sample per channel via a valid/ready handshake and writes it at that channel's write pointer.
- Then streams the NumTaps most recent samples of that channel, newest first, to the MAC stage.
- Clears its memory to zero after reset, so the first outputs never contain stale data.

---
 rtl/student_sample_ring.sv | 163 ++++++++++++++++
 tb/tb_student_sample_ring.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/student_sample_ring.sv
// student_sample_ring
//
// Multi-channel circular sample history buffer feeding the FIR MAC stage.
// One inferred single-clock block RAM (read-first, read latency 1) holds
// NumChannels rings of 2**AddrWidth samples each, addressed as {ch, offset}.
// After reset the whole RAM is cleared to zero. Each accepted sample is written
// at its channel's write pointer, and then the NumTaps most recent samples of
// that channel are streamed out, newest first.
//
// Ports:
//   clk_i           system clock
//   rst_i           synchronous, active-high reset
//   sample_valid_i  new sample offered
//   sample_ready_o  sample can be accepted (IDLE only)
//   sample_ch_i     channel of the offered sample
//   sample_i        sample value
//   out_valid_o     out_data_o holds a history sample (no backpressure)
//   out_data_o      history sample
//   out_tap_o       tap index, 0 = newest
//   out_ch_o        channel of the current burst
//   out_last_o      high with the final tap
//   busy_o          high in every state except IDLE

module student_sample_ring #(
    parameter int unsigned DataSize    = 16,
    parameter int unsigned AddrWidth   = 6,
    parameter int unsigned NumChannels = 2,
    parameter int unsigned NumTaps     = 8,
    parameter int unsigned ChWidth     = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sample_valid_i,
    output logic                 sample_ready_o,
    input  logic [ChWidth-1:0]   sample_ch_i,
    input  logic [DataSize-1:0]  sample_i,
    output logic                 out_valid_o,
    output logic [DataSize-1:0]  out_data_o,
    output logic [AddrWidth-1:0] out_tap_o,
    output logic [ChWidth-1:0]   out_ch_o,
    output logic                 out_last_o,
    output logic                 busy_o
);

    localparam int unsigned Depth = NumChannels * (2 ** AddrWidth);
    localparam int unsigned MemAw = ChWidth + AddrWidth;
    localparam logic [MemAw-1:0]     LastAddr = MemAw'(Depth - 1);
    localparam logic [AddrWidth-1:0] LastTap  = AddrWidth'(NumTaps - 1);

    typedef enum logic [1:0] {StClear, StIdle, StRead, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [MemAw-1:0]       clear_cnt_q, clear_cnt_d;
    logic [AddrWidth-1:0]   wptr_q [NumChannels];
    logic [ChWidth-1:0]     ch_q;
    logic [AddrWidth-1:0]   rd_ptr_q;
    logic [AddrWidth-1:0]   tap_q, tap_d;

    logic                   accept;
    logic                   rd_en;
    logic                   mem_we;
    logic [MemAw-1:0]       mem_waddr;
    logic [MemAw-1:0]       mem_raddr;
    logic [DataSize-1:0]    mem_wdata;
    logic [DataSize-1:0]    mem_q [Depth];

    assign sample_ready_o = (state_q == StIdle);
    assign busy_o         = (state_q != StIdle);
    assign accept         = sample_valid_i && sample_ready_o;
    assign rd_en          = (state_q == StRead);
    // Offset subtraction wraps within the channel's ring.
    assign mem_raddr      = {ch_q, rd_ptr_q - tap_q};

    always_comb begin
        state_d     = state_q;
        clear_cnt_d = clear_cnt_q;
        tap_d       = tap_q;
        mem_we      = 1'b0;
        mem_waddr   = clear_cnt_q;
        mem_wdata   = '0;
        unique case (state_q)
            StClear: begin
                mem_we      = 1'b1;
                clear_cnt_d = clear_cnt_q + 1'b1;
                if (clear_cnt_q == LastAddr) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (accept) begin
                    mem_we    = 1'b1;
                    mem_waddr = {sample_ch_i, wptr_q[sample_ch_i]};
                    mem_wdata = sample_i;
                    tap_d     = '0;
                    state_d   = StRead;
                end
            end
            StRead: begin
                tap_d = tap_q + 1'b1;
                if (tap_q == LastTap) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StClear;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StClear;
            clear_cnt_q <= '0;
            for (int i = 0; i < int'(NumChannels); i++) begin
                wptr_q[i] <= '0;
            end
            ch_q     <= '0;
            rd_ptr_q <= '0;
            tap_q    <= '0;
        end else begin
            state_q     <= state_d;
            clear_cnt_q <= clear_cnt_d;
            tap_q       <= tap_d;
            if (accept) begin
                wptr_q[sample_ch_i] <= wptr_q[sample_ch_i] + 1'b1;
                ch_q                <= sample_ch_i;
                // Tap 0 reads the slot just written; it lands one cycle later,
                // so read-first never returns the stale value.
                rd_ptr_q            <= wptr_q[sample_ch_i];
            end
        end
    end

    // RAM write port; no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // RAM read port plus aligned sideband; data holds outside bursts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            out_data_o  <= '0;
            out_tap_o   <= '0;
            out_ch_o    <= '0;
        end else begin
            out_valid_o <= rd_en;
            out_last_o  <= rd_en && (tap_q == LastTap);
            if (rd_en) begin
                out_data_o <= mem_q[mem_raddr];
                out_tap_o  <= tap_q;
                out_ch_o   <= ch_q;
            end
        end
    end

endmodule

// File: tb/tb_student_sample_ring.sv
module tb_student_sample_ring;

    localparam int DataSize  = 16;
    localparam int AddrWidth = 6;
    localparam int NumTaps   = 8;
    localparam int ChWidth   = 1;
    localparam int Ring      = 64;

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 sample_valid_i = 1'b0;
    logic [ChWidth-1:0]   sample_ch_i = '0;
    logic [DataSize-1:0]  sample_i = '0;
    logic                 sample_ready_o;
    logic                 out_valid_o;
    logic [DataSize-1:0]  out_data_o;
    logic [AddrWidth-1:0] out_tap_o;
    logic [ChWidth-1:0]   out_ch_o;
    logic                 out_last_o;
    logic                 busy_o;

    student_sample_ring dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .sample_ch_i    (sample_ch_i),
        .sample_i       (sample_i),
        .out_valid_o    (out_valid_o),
        .out_data_o     (out_data_o),
        .out_tap_o      (out_tap_o),
        .out_ch_o       (out_ch_o),
        .out_last_o     (out_last_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference history: per-channel ring and write pointer.
    logic [DataSize-1:0] hist [2][Ring];
    int                  wp [2];
    logic [DataSize-1:0] burst [NumTaps];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            wp[c] = 0;
            for (int i = 0; i < Ring; i++) hist[c][i] = '0;
        end
    endtask

    // Called right after the last reset edge; counts CLEAR cycles.
    task automatic clear_check(input string tag);
        int n = 0;
        int vseen = 0;
        while (busy_o && n < 1000) begin
            if (out_valid_o) vseen++;
            n++;
            tick();
        end
        check({tag, "_clear_len"}, n, 128);
        check({tag, "_ready_after_clear"}, sample_ready_o, 1);
        check({tag, "_no_valid_in_clear"}, vseen, 0);
    endtask

    task automatic send(input int ch, input logic [DataSize-1:0] d);
        int guard = 0;
        while (!sample_ready_o && guard < 400) begin
            tick();
            guard++;
        end
        check("ready_wait", sample_ready_o, 1);
        sample_ch_i    = ChWidth'(ch);
        sample_i       = d;
        sample_valid_i = 1'b1;
        tick();
        sample_valid_i = 1'b0;
        hist[ch][wp[ch]] = d;
        wp[ch] = (wp[ch] + 1) % Ring;
        check("ready_low_accept", sample_ready_o, 0);
        check("valid_gap", out_valid_o, 0);
        for (int k = 0; k < NumTaps; k++) begin
            tick();
            burst[k] = out_data_o;
            check("tap_valid", out_valid_o, 1);
            check("tap_data", out_data_o, hist[ch][(wp[ch] - 1 - k + Ring) % Ring]);
            check("tap_idx", out_tap_o, k);
            check("tap_ch", out_ch_o, ch);
            check("tap_last", out_last_o, (k == NumTaps - 1));
            check("ready_low_burst", sample_ready_o, 0);
        end
        tick();
        check("ready_back", sample_ready_o, 1);
        check("valid_end", out_valid_o, 0);
    endtask

    initial begin
        int cyc;
        int last_acc;
        int n_acc;
        bit acc;
        logic [DataSize-1:0] q [$];

        model_reset();

        // Reset state and CLEAR length.
        rst_i = 1'b1;
        repeat (3) tick();
        check("rst_valid", out_valid_o, 0);
        check("rst_last", out_last_o, 0);
        check("rst_data", out_data_o, 0);
        check("rst_tap", out_tap_o, 0);
        check("rst_ch", out_ch_o, 0);
        check("rst_ready", sample_ready_o, 0);
        check("rst_busy", busy_o, 1);
        rst_i = 1'b0;
        clear_check("init");

        // Single sample: itself, then seven zeros.
        send(0, 16'h0001);
        check("single_tap0", burst[0], 16'h0001);
        check("single_tap7", burst[7], 16'h0000);

        // Ring wrap: ch0 values 1..70.
        for (int i = 1; i <= 70; i++) send(0, DataSize'(i));
        check("wrap_tap0", burst[0], 70);
        check("wrap_tap7", burst[7], 63);

        // Channel interleave.
        for (int i = 0; i < 5; i++) begin
            send(0, DataSize'(16'h1000 + i));
            send(1, DataSize'(16'h2000 + i));
        end
        check("ilv_tap0", burst[0], 16'h2004);
        check("ilv_tap4", burst[4], 16'h2000);
        check("ilv_tap5", burst[5], 16'h0000);

        // Reset at tap 3 of a burst.
        sample_ch_i    = 1'b0;
        sample_i       = 16'h0055;
        sample_valid_i = 1'b1;
        tick();
        sample_valid_i = 1'b0;
        repeat (4) tick();
        check("abort_at_tap3", out_tap_o, 3);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("abort_valid", out_valid_o, 0);
        check("abort_busy", busy_o, 1);
        check("abort_data", out_data_o, 0);
        model_reset();
        clear_check("abort");
        send(0, 16'h00AB);
        check("post_rst_tap0", burst[0], 16'h00AB);
        check("post_rst_tap1", burst[1], 16'h0000);

        // Continuous valid: accepts every NumTaps+2 cycles, scoreboarded.
        cyc = 0;
        last_acc = -1;
        n_acc = 0;
        sample_ch_i = 1'b0;
        sample_i = 16'h3000;
        sample_valid_i = 1'b1;
        for (int i = 0; i < 65; i++) begin
            if (out_valid_o && out_tap_o == 0) begin
                if (q.size() > 0) check("sb_tap0", out_data_o, q.pop_front());
                else check("sb_unexpected", 1, 0);
            end
            acc = sample_ready_o;
            if (acc) begin
                if (last_acc >= 0) check("acc_spacing", cyc - last_acc, NumTaps + 2);
                last_acc = cyc;
                q.push_back(sample_i);
                n_acc++;
            end
            tick();
            cyc++;
            if (acc) begin
                sample_i    = sample_i + 1'b1;
                sample_ch_i = ~sample_ch_i;
            end
        end
        sample_valid_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid_o && out_tap_o == 0) begin
                if (q.size() > 0) check("sb_tap0", out_data_o, q.pop_front());
                else check("sb_unexpected", 1, 0);
            end
            tick();
        end
        check("sb_empty", q.size(), 0);
        check("acc_count", n_acc, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
